// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port DW-bit data memory among NREQ requesters.
//            One request is accepted at a time through a valid/ready
//            handshake. The winner gets one memory access cycle (ACCESS),
//            followed by a registered one-cycle response strobe (RESP) that
//            carries the read data, or the pre-write contents as a write ack.
//
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/ready   - per-requester handshake (ready one-hot/zero)
//            req_we/addr/wdata - packed per-requester request fields
//            rsp_valid         - one-cycle response strobe to the owner
//            rsp_rdata         - shared response data bus
//            mem_we/addr/wdata - memory access controls
//            mem_rdata         - memory read data (combinational from addr)
//            busy              - high in ACCESS and RESP
//
// Config   : DMEM_ARB_FIXED_PRIO_EN - when defined, lowest-index valid
//            requester always wins; otherwise round-robin arbitration.
//
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 10,
  parameter int DW   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [NREQ-1:0]   r_owner_oh;

  logic              w_window;
  logic              w_grant;
  logic [NREQ-1:0]   w_sel;
  logic              w_win_we;
  logic [AW-1:0]     w_win_addr;
  logic [DW-1:0]     w_win_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     w_win;
`endif

  // Unpacked views of the packed request buses.
  logic [AW-1:0]     w_addr_arr  [NREQ];
  logic [DW-1:0]     w_wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign w_wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  // Accept window: IDLE and RESP both take a new request.
  assign w_window = (r_state == ST_IDLE) || (r_state == ST_RESP);

  // Winner selection.
  always_comb begin
    w_grant     = 1'b0;
    w_sel       = '0;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    w_win       = '0;
    // Round-robin as two ordered passes: first the indices above ptr,
    // then wrap around to 0..ptr. Equivalent to starting at ptr+1 mod NREQ.
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant && req_valid[i] && (PW'(i) > r_ptr)) begin
        w_grant     = 1'b1;
        w_sel[i]    = 1'b1;
        w_win       = PW'(i);
        w_win_we    = req_we[i];
        w_win_addr  = w_addr_arr[i];
        w_win_wdata = w_wdata_arr[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant && req_valid[i] && (PW'(i) <= r_ptr)) begin
        w_grant     = 1'b1;
        w_sel[i]    = 1'b1;
        w_win       = PW'(i);
        w_win_we    = req_we[i];
        w_win_addr  = w_addr_arr[i];
        w_win_wdata = w_wdata_arr[i];
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant && req_valid[i]) begin
        w_grant     = 1'b1;
        w_sel[i]    = 1'b1;
        w_win_we    = req_we[i];
        w_win_addr  = w_addr_arr[i];
        w_win_wdata = w_wdata_arr[i];
      end
    end
`endif
  end

  // Ready is suppressed while rst is high so nothing looks accepted during
  // a reset cycle.
  assign req_ready = (w_window && !rst) ? w_sel : '0;

  // Gating with rst keeps an abandoned access from committing its write.
  assign mem_we    = (r_state == ST_ACCESS) && r_we && !rst;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_owner_oh <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_ptr      <= PW'(NREQ - 1);
      r_owner    <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_grant) begin
            r_we       <= w_win_we;
            r_addr     <= w_win_addr;
            r_wdata    <= w_win_wdata;
            r_owner_oh <= w_sel;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_owner    <= w_win;
`endif
            r_state    <= ST_ACCESS;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Capture happens before the write commits, so a write ack
          // carries the old contents of the addressed word.
          rsp_rdata <= mem_rdata;
          rsp_valid <= r_owner_oh;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          r_ptr     <= r_owner;
`endif
          r_state   <= ST_RESP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a behavioural memory,
//            a reference memory image and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 10;
  localparam int DW   = 256;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;
  logic                 busy;

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory and an independent reference image.
  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t sb[$];
  int   rsp_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   we_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_we === 1'b1) we_cycles++;
      if (rsp_valid !== '0) begin
        rsp_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_rsp rsp_valid=%b required=00", rsp_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_valid !== e.oh || rsp_rdata !== e.data) begin
            failures++;
            $display("FAIL rsp_match rsp_valid=%b data=%h required %b data=%h",
                     rsp_valid, rsp_rdata[63:0], e.oh, e.data[63:0]);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives a request, waits for its grant, records the expected response.
  // Returns in the ACCESS cycle (just after the accepting edge).
  task automatic issue(input int r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int n;
    exp_t e;
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    n = 0;
    @(negedge clk);
    while (req_ready[r] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[r] !== 1'b1) begin
      failures++;
      $display("FAIL grant_timeout req=%0d ready=%b required ready bit set", r, req_ready);
    end else begin
      e.oh   = NREQ'(1) << r;
      e.data = ref_mem[a];
      sb.push_back(e);
      if (we) ref_mem[a] = d;
    end
    sync();
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain pending=%0d busy=%b required 0 and 0", sb.size(), busy);
    end
    sync();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b rsp=%b we=%b busy=%b required all 0",
               req_ready, rsp_valid, mem_we, busy);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || rsp_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h required 0",
               mem_addr, mem_wdata[31:0], rsp_rdata[31:0]);
    end
    req_valid = '0;
    sync();
    rst = 1'b0;
    sync();
  endtask

  task automatic test_basic_read();
    issue(0, 1'b0, AW'(0), '0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== AW'(0) || busy !== 1'b1) begin
      failures++;
      $display("FAIL read_access we=%b addr=%h busy=%b required 0 000 1", mem_we, mem_addr, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== {8{32'hBEEFCAFE}}) begin
      failures++;
      $display("FAIL read_rsp rsp=%b data=%h required 01 beefcafe", rsp_valid, rsp_rdata[31:0]);
    end
    drain();
  endtask

  task automatic test_write_read();
    int w0;
    rsp_cyc.delete();
    w0 = we_cycles;
    issue(1, 1'b1, AW'(5), DW'(256'h1234));
    issue(1, 1'b0, AW'(5), '0);
    drain();
    checks++;
    if (we_cycles - w0 != 1) begin
      failures++;
      $display("FAIL write_we_len cycles=%0d required 1", we_cycles - w0);
    end
    checks++;
    if (rsp_cyc.size() != 2 || rsp_cyc[1] - rsp_cyc[0] != 2) begin
      failures++;
      $display("FAIL write_read_gap count=%0d gap=%0d required 2 and 2", rsp_cyc.size(),
               (rsp_cyc.size() == 2) ? rsp_cyc[1] - rsp_cyc[0] : -1);
    end
    checks++;
    if (mem[5] !== DW'(256'h1234)) begin
      failures++;
      $display("FAIL write_commit mem5=%h required 1234", mem[5][31:0]);
    end
  endtask

  task automatic test_round_robin();
    int grants;
    int n;
    logic [NREQ-1:0] exp_oh;
    exp_t e;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr[0*AW +: AW] = AW'(10);
    req_addr[1*AW +: AW] = AW'(11);
    grants = 0;
    n = 0;
    while (grants < 6 && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready !== '0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_oh = 2'b01;
`else
        exp_oh = (grants % 2 == 0) ? 2'b01 : 2'b10;
`endif
        checks++;
        if (req_ready !== exp_oh) begin
          failures++;
          $display("FAIL rr_grant idx=%0d ready=%b required %b", grants, req_ready, exp_oh);
        end
        e.oh   = exp_oh;
        e.data = ref_mem[(exp_oh == 2'b01) ? 10 : 11];
        sb.push_back(e);
        grants++;
      end
    end
    checks++;
    if (grants != 6) begin
      failures++;
      $display("FAIL rr_count grants=%0d required 6", grants);
    end
    sync();
    req_valid = '0;
    drain();
  endtask

  task automatic test_back_to_back();
    rsp_cyc.delete();
    issue(0, 1'b0, AW'(1), '0);
    issue(0, 1'b0, AW'(2), '0);
    issue(0, 1'b0, AW'(3), '0);
    drain();
    checks++;
    if (rsp_cyc.size() != 3 || rsp_cyc[1] - rsp_cyc[0] != 2 || rsp_cyc[2] - rsp_cyc[1] != 2) begin
      failures++;
      $display("FAIL b2b_spacing count=%0d required 3 strobes 2 cycles apart", rsp_cyc.size());
    end
  endtask

  task automatic test_reset_abort();
    int n;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1*AW +: AW]  = AW'(7);
    req_wdata[1*DW +: DW] = DW'(256'hFF);
    n = 0;
    @(negedge clk);
    while (req_ready[1] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    sync();
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL abort_we we=%b required 0", mem_we);
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[7] !== ref_mem[7]) begin
      failures++;
      $display("FAIL abort_mem mem7=%h required %h", mem[7][31:0], ref_mem[7][31:0]);
    end
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        rsp_rdata !== '0) begin
      failures++;
      $display("FAIL abort_state rsp=%b busy=%b addr=%h required all 0", rsp_valid, busy, mem_addr);
    end
    repeat (3) @(negedge clk);
    sync();
  endtask

  task automatic test_withdraw();
    issue(1, 1'b0, AW'(20), '0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0*AW +: AW] = AW'(30);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      failures++;
      $display("FAIL withdraw_ready ready=%b required 00", req_ready);
    end
    sync();
    req_valid[0] = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_idle busy=%b required 0", busy);
    end
    sync();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = {8{32'(i) ^ 32'hA5A50000}};
      ref_mem[i] = {8{32'(i) ^ 32'hA5A50000}};
    end
    mem[0]     = {8{32'hBEEFCAFE}};
    ref_mem[0] = {8{32'hBEEFCAFE}};
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    sync();
    test_reset();
    test_basic_read();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_reset_abort();
    test_withdraw();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
